// File: rtl/pkg_frame_if.sv
// Word-in / byte-out link bundle for pkg_frame.
// Carries the chip-packet word stream with its done pulse and the byte-wide valid/ready transmit side.
// slave is the frame block's view; master is the view of whoever drives the words and sinks the bytes.
interface pkg_frame_if;
  logic [15:0] pchip_d;
  logic        pchip_vld;
  logic        pchip_done;
  logic [7:0]  tx_d;
  logic        tx_vld;
  logic        tx_rdy;

  modport master (
    output pchip_d, pchip_vld, tx_rdy,
    input  pchip_done, tx_d, tx_vld
  );

  modport slave (
    input  pchip_d, pchip_vld, tx_rdy,
    output pchip_done, tx_d, tx_vld
  );
endinterface

// File: rtl/pkg_frame.sv
// pkg_frame: sink for the packet-chip push stage.
// Words are buffered in a FIFO, and a 16-bit checksum is appended to each frame.
// The buffered words are sent out high byte first on a byte-wide valid/ready link.
module pkg_frame #(
  parameter int FIFO_AW = 8
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [19:0] chip_len,
  pkg_frame_if.slave  pif,
  output logic [15:0] frame_cnt,
  output logic        err_sync,
  output logic        err_proto
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0] SYNC = 16'h5331;

  typedef enum logic [1:0] {I_HDR, I_BODY, I_CSUM} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_RD, O_HI, O_LO} out_state_t;

  logic [15:0] in_reg;
  logic        pend;
  in_state_t   in_state, in_state_next;
  logic [12:0] len, len_next, wcnt, wcnt_next, len_sample;
  logic [15:0] sum, sum_next, wr_data;
  logic        consume, sync_err, wr_en, rd_en, frame_done;

  logic [15:0]        mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty;
  logic [15:0]        rd_q, out_reg;
  out_state_t         out_state, out_state_next;
  logic [7:0]         tx_byte;
  logic               tx_valid;

  // Only the low 12 bits of chip_len carry a length; the upper bits are folded away here.
  logic unused_len_hi;
  assign unused_len_hi = ^chip_len[19:12];

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign len_sample = (chip_len[11:0] == 12'd0) ? 13'd4096 : {1'b0, chip_len[11:0]};

  assign pif.pchip_done = consume;
  assign pif.tx_d       = tx_byte;
  assign pif.tx_vld     = tx_valid;

  // Input holding register: a new word is taken only when none is pending, otherwise it is a protocol error.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      in_reg    <= '0;
      pend      <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (pif.pchip_vld && pend) err_proto <= 1'b1;
      if (pif.pchip_vld && !pend) begin
        in_reg <= pif.pchip_d;
        pend   <= 1'b1;
      end else if (consume) begin
        pend <= 1'b0;
      end
    end
  end

  // Input FSM state, frame length, word count, running sum and the sticky/frame counters.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= I_HDR;
      len       <= '0;
      wcnt      <= '0;
      sum       <= '0;
      err_sync  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      in_state <= in_state_next;
      len      <= len_next;
      wcnt     <= wcnt_next;
      sum      <= sum_next;
      if (sync_err)   err_sync  <= 1'b1;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Input FSM decode: header check, body accumulation and checksum insertion.
  always_comb begin
    in_state_next = in_state;
    len_next      = len;
    wcnt_next     = wcnt;
    sum_next      = sum;
    consume       = 1'b0;
    sync_err      = 1'b0;
    wr_en         = 1'b0;
    wr_data       = in_reg;
    frame_done    = 1'b0;
    case (in_state)
      I_HDR: begin
        if (pend) begin
          if (in_reg == SYNC) begin
            if (!full) begin
              wr_en         = 1'b1;
              consume       = 1'b1;
              len_next      = len_sample;
              sum_next      = SYNC;
              wcnt_next     = 13'd1;
              in_state_next = I_BODY;
            end
          end else begin
            // A stray word is acknowledged so the producer does not stall, but it is never buffered.
            consume  = 1'b1;
            sync_err = 1'b1;
          end
        end
      end
      I_BODY: begin
        if (pend && !full) begin
          wr_en     = 1'b1;
          consume   = 1'b1;
          sum_next  = sum + in_reg;
          wcnt_next = wcnt + 13'd1;
          if (wcnt + 13'd1 == len + 13'd3) in_state_next = I_CSUM;
        end
      end
      I_CSUM: begin
        // Any word that is already pending waits here untouched until the header state sees it.
        if (!full) begin
          wr_en         = 1'b1;
          wr_data       = sum;
          frame_done    = 1'b1;
          in_state_next = I_HDR;
        end
      end
      default: in_state_next = I_HDR;
    endcase
  end

  // FIFO pointers and occupancy; write and read callers already honour full/empty.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage with registered read, kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_ptr];
  end

  // Output FSM state and the word being serialized.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= O_IDLE;
      out_reg   <= '0;
    end else begin
      out_state <= out_state_next;
      if (out_state == O_RD) out_reg <= rd_q;
    end
  end

  // Output FSM decode: fetch one word, then hold each byte until the sink takes it.
  always_comb begin
    out_state_next = out_state;
    rd_en          = 1'b0;
    tx_valid       = 1'b0;
    tx_byte        = 8'h00;
    case (out_state)
      O_IDLE: begin
        if (!empty) begin
          rd_en          = 1'b1;
          out_state_next = O_RD;
        end
      end
      O_RD: out_state_next = O_HI;
      O_HI: begin
        tx_valid = 1'b1;
        tx_byte  = out_reg[15:8];
        if (pif.tx_rdy) out_state_next = O_LO;
      end
      O_LO: begin
        tx_valid = 1'b1;
        tx_byte  = out_reg[7:0];
        if (pif.tx_rdy) out_state_next = O_IDLE;
      end
      default: out_state_next = O_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pkg_frame.sv
// Directed-sequence bench for pkg_frame with randomized frame contents.
// The expected byte stream is built frame by frame from the word list: every word high byte first,
// then the 16-bit sum of all the frame's words.
module tb_pkg_frame;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [19:0] chip_len;
  logic [15:0] frame_cnt;
  logic        err_sync, err_proto;

  pkg_frame_if bus ();

  pkg_frame #(.FIFO_AW(2)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .chip_len  (chip_len),
    .pif       (bus),
    .frame_cnt (frame_cnt),
    .err_sync  (err_sync),
    .err_proto (err_proto)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [15:0] frame_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_d = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte monitor: records every transfer and checks that a stalled byte is held unchanged.
  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_vld", {31'd0, bus.tx_vld}, 32'd1);
        check("stall_d", {24'd0, bus.tx_d}, {24'd0, prev_d});
      end
      if (bus.tx_vld && bus.tx_rdy) rx_q.push_back(bus.tx_d);
      prev_stall = bus.tx_vld && !bus.tx_rdy;
      prev_d     = bus.tx_d;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic make_frame(input int dlen);
    frame_q.delete();
    frame_q.push_back(16'h5331);
    for (int i = 0; i < dlen + 2; i++) frame_q.push_back(16'($urandom));
  endtask

  // Reference: the frame's words in order, then their 16-bit sum.
  task automatic model_frame();
    logic [15:0] s;
    s = 16'h0000;
    foreach (frame_q[i]) begin
      exp_q.push_back(frame_q[i][15:8]);
      exp_q.push_back(frame_q[i][7:0]);
      s = s + frame_q[i];
    end
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
  endtask

  task automatic pulse(input logic [15:0] w);
    @(posedge clk_sys); #1;
    bus.pchip_d   = w;
    bus.pchip_vld = 1'b1;
    @(posedge clk_sys); #1;
    bus.pchip_vld = 1'b0;
  endtask

  // Returns the cycle (1 = right after the vld cycle) in which done was seen, or 0 if the budget ran out.
  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_sys);
      if (bus.pchip_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic send_range(input string tag, input int first, input int last, input bit want_fast);
    int lat;
    for (int i = first; i <= last; i++) begin
      pulse(frame_q[i]);
      wait_done(want_fast ? 50 : 400, lat);
      if (want_fast) check($sformatf("%s_lat%0d", tag, i), lat, 1);
      else           check($sformatf("%s_done%0d", tag, i), {31'd0, lat > 0}, 32'd1);
    end
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (rx_q.size() < exp_q.size() && c < 3000) begin
      @(posedge clk_sys);
      c++;
    end
    repeat (12) @(posedge clk_sys);
    check($sformatf("%s_nbytes", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int lat;
    rst_n         = 1'b0;
    chip_len      = 20'd0;
    bus.pchip_d   = 16'h0000;
    bus.pchip_vld = 1'b0;
    bus.tx_rdy    = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
    check("rst_tx_d", {24'd0, bus.tx_d}, 32'd0);
    check("rst_done", {31'd0, bus.pchip_done}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_err_sync", {31'd0, err_sync}, 32'd0);
    check("rst_err_proto", {31'd0, err_proto}, 32'd0);
    rst_n = 1'b1;

    // Basic frame with known contents and a free-running sink.
    chip_len = 20'd2;
    frame_q  = '{16'h5331, 16'h0005, 16'h0000, 16'h1111, 16'h2222};
    model_frame();
    send_range("t1", 0, 4, 1'b1);
    drain("t1");
    check("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("t1_err_sync", {31'd0, err_sync}, 32'd0);
    check("t1_err_proto", {31'd0, err_proto}, 32'd0);

    // Stalled sink: four words fill the FIFO and one sits in the output register, then done is withheld.
    @(posedge clk_sys); #1;
    bus.tx_rdy = 1'b0;
    chip_len   = 20'd8;
    make_frame(8);
    model_frame();
    send_range("t2", 0, 4, 1'b1);
    pulse(frame_q[5]);
    wait_done(20, lat);
    check("t2_full_hold", lat, 0);
    @(posedge clk_sys); #1;
    bus.tx_rdy = 1'b1;
    wait_done(400, lat);
    check("t2_resume", {31'd0, lat > 0}, 32'd1);
    send_range("t2", 6, 10, 1'b0);
    drain("t2");
    check("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // A stray word before a header is acknowledged, flagged and dropped.
    chip_len = 20'd1;
    pulse(16'h1234);
    wait_done(50, lat);
    check("t3_stray_lat", lat, 1);
    @(posedge clk_sys); #1;
    check("t3_err_sync", {31'd0, err_sync}, 32'd1);
    frame_q = '{16'h5331, 16'h0001, 16'h0002, 16'hFFFF};
    model_frame();
    send_range("t3", 0, 3, 1'b1);
    drain("t3");
    check("t3_frame_cnt", {16'd0, frame_cnt}, 32'd3);

    // Back-to-back vld: the second word is a protocol error and never enqueued.
    check("t4_err_proto_pre", {31'd0, err_proto}, 32'd0);
    chip_len = 20'd1;
    make_frame(1);
    model_frame();
    @(posedge clk_sys); #1;
    bus.pchip_d   = frame_q[0];
    bus.pchip_vld = 1'b1;
    @(posedge clk_sys); #1;
    bus.pchip_d   = 16'hDEAD;
    @(negedge clk_sys);
    check("t4_first_done", {31'd0, bus.pchip_done}, 32'd1);
    @(posedge clk_sys); #1;
    bus.pchip_vld = 1'b0;
    @(negedge clk_sys);
    check("t4_err_proto", {31'd0, err_proto}, 32'd1);
    check("t4_second_done", {31'd0, bus.pchip_done}, 32'd0);
    send_range("t4", 1, 3, 1'b1);
    drain("t4");
    check("t4_frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // Next header arrives while the checksum is blocked by a full FIFO.
    @(posedge clk_sys); #1;
    bus.tx_rdy = 1'b0;
    chip_len   = 20'd2;
    make_frame(2);
    model_frame();
    send_range("t5a", 0, 4, 1'b1);
    make_frame(2);
    model_frame();
    pulse(frame_q[0]);
    wait_done(20, lat);
    check("t5_hdr_hold", lat, 0);
    check("t5_cnt_hold", {16'd0, frame_cnt}, 32'd4);
    @(posedge clk_sys); #1;
    bus.tx_rdy = 1'b1;
    wait_done(400, lat);
    check("t5_hdr_done", {31'd0, lat > 0}, 32'd1);
    check("t5_cnt_at_hdr", {16'd0, frame_cnt}, 32'd5);
    send_range("t5b", 1, 4, 1'b0);
    drain("t5");
    check("t5_frame_cnt", {16'd0, frame_cnt}, 32'd6);

    // Reset in the middle of a frame with bytes waiting on a stalled sink.
    @(posedge clk_sys); #1;
    bus.tx_rdy = 1'b0;
    chip_len   = 20'd4;
    make_frame(4);
    send_range("t6a", 0, 2, 1'b1);
    repeat (4) @(negedge clk_sys);
    check("t6_vld_before", {31'd0, bus.tx_vld}, 32'd1);
    @(posedge clk_sys); #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_vld", {31'd0, bus.tx_vld}, 32'd0);
    check("t6_async_cnt", {16'd0, frame_cnt}, 32'd0);
    check("t6_async_err", {30'd0, err_sync, err_proto}, 32'd0);
    repeat (2) @(posedge clk_sys); #1;
    rst_n      = 1'b1;
    bus.tx_rdy = 1'b1;
    repeat (20) @(posedge clk_sys);
    check("t6_quiet", rx_q.size(), 0);
    chip_len = 20'd3;
    make_frame(3);
    model_frame();
    send_range("t6b", 0, 5, 1'b1);
    drain("t6");
    check("t6_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
